// File: rtl/hb_domain_if.sv
// Per-domain HB bus bundle: controller (master) drives selects and mapped
// fields, the domain responder (slave) returns read data and finish strobes.
interface hb_domain_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  ren;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [31:0]           wdata;
    logic [1:0]            write_width;
    logic [31:0]           rdata;
    logic                  read_finish;
    logic                  write_finish;

    modport master (
        output ren, wen, raddr, waddr, wdata, write_width,
        input  rdata, read_finish, write_finish
    );

    modport slave (
        input  ren, wen, raddr, waddr, wdata, write_width,
        output rdata, read_finish, write_finish
    );
endinterface

// File: rtl/hb_domain_responder.sv
// HB domain responder: register scratchpad with independent read/write
// channels, each finishing after a fixed number of wait states.
module hb_domain_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    hb_domain_if.slave  bus
);
    localparam int          IDX_W  = ADDR_WIDTH - 2;
    localparam int          MEM_AW = $clog2(DEPTH);
    localparam logic [3:0]  RWAIT  = 4'(READ_WAIT);
    localparam logic [3:0]  WWAIT  = 4'(WRITE_WAIT);

    logic [3:0]  rcnt_q, rcnt_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    logic [IDX_W-1:0] ridx, widx;
    logic             rin_range, win_range;
    logic             rfin, wfin;
    logic [3:0]       be;
    logic [31:0]      wlane;
    logic             unused_addr_bits;

    assign ridx      = bus.raddr[ADDR_WIDTH-1:2];
    assign widx      = bus.waddr[ADDR_WIDTH-1:2];
    assign rin_range = 32'(ridx) < DEPTH;
    assign win_range = 32'(widx) < DEPTH;

    // Finish strobes depend only on select and counter, never on data.
    assign rfin = bus.ren && (rcnt_q == RWAIT);
    assign wfin = bus.wen && (wcnt_q == WWAIT);

    assign bus.read_finish  = rfin;
    assign bus.write_finish = wfin;

    // Reads return the whole aligned word; byte offset is irrelevant.
    assign unused_addr_bits = ^bus.raddr[1:0];

    always_comb begin
        bus.rdata = 32'h0;
        if (rfin && rin_range)
            bus.rdata = mem_q[ridx[MEM_AW-1:0]];
    end

    always_comb begin
        rcnt_d = 4'd0;
        if (bus.ren && !rfin)
            rcnt_d = rcnt_q + 4'd1;
        wcnt_d = 4'd0;
        if (bus.wen && !wfin)
            wcnt_d = wcnt_q + 4'd1;
    end

    // Byte-enable decode; misaligned and reserved widths yield no enables.
    always_comb begin
        be    = 4'b0000;
        wlane = bus.wdata;
        case (bus.write_width)
            2'd0: begin
                be    = 4'b0001 << bus.waddr[1:0];
                wlane = {4{bus.wdata[7:0]}};
            end
            2'd1: begin
                wlane = {2{bus.wdata[15:0]}};
                if (!bus.waddr[0])
                    be = bus.waddr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                if (bus.waddr[1:0] == 2'b00)
                    be = 4'b1111;
            end
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            mem_d[i] = mem_q[i];
        if (wfin && win_range) begin
            for (int b = 0; b < 4; b++)
                if (be[b])
                    mem_d[widx[MEM_AW-1:0]][8*b +: 8] = wlane[8*b +: 8];
        end
    end

    // Reset wins over a write finishing in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt_q <= 4'd0;
            wcnt_q <= 4'd0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 32'h0;
        end else begin
            rcnt_q <= rcnt_d;
            wcnt_q <= wcnt_d;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= mem_d[i];
        end
    end
endmodule

// File: tb/tb_hb_domain_responder.sv
// Directed bench for hb_domain_responder: three instances cover the default,
// slow-read and single-wait configurations.
module tb_hb_domain_responder;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    hb_domain_if #(.ADDR_WIDTH(8)) bus_a ();
    hb_domain_if #(.ADDR_WIDTH(8)) bus_b ();
    hb_domain_if #(.ADDR_WIDTH(8)) bus_c ();

    hb_domain_responder #(.ADDR_WIDTH(8), .DEPTH(16), .READ_WAIT(1), .WRITE_WAIT(2))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    hb_domain_responder #(.ADDR_WIDTH(8), .DEPTH(16), .READ_WAIT(3), .WRITE_WAIT(2))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    hb_domain_responder #(.ADDR_WIDTH(8), .DEPTH(16), .READ_WAIT(1), .WRITE_WAIT(1))
        u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_a.ren = 0; bus_a.wen = 0; bus_a.raddr = 0; bus_a.waddr = 0;
        bus_a.wdata = 0; bus_a.write_width = 0;
        bus_b.ren = 0; bus_b.wen = 0; bus_b.raddr = 0; bus_b.waddr = 0;
        bus_b.wdata = 0; bus_b.write_width = 0;
        bus_c.ren = 0; bus_c.wen = 0; bus_c.raddr = 0; bus_c.waddr = 0;
        bus_c.wdata = 0; bus_c.write_width = 0;
    endtask

    // Drive-only helpers for instance A (wait states 1 read, 2 write).
    task automatic a_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [1:0] width);
        bus_a.wen = 1; bus_a.waddr = addr; bus_a.wdata = data; bus_a.write_width = width;
        repeat (3) step();
        bus_a.wen = 0;
    endtask

    task automatic a_read(input logic [7:0] addr, output logic fin, output logic [31:0] data);
        bus_a.ren = 1; bus_a.raddr = addr;
        step();
        #1;
        fin  = bus_a.read_finish;
        data = bus_a.rdata;
        step();
        bus_a.ren = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_all();
        step(); step();
        rst_n = 1;
        #1;
        total++;
        if (bus_a.rdata !== 32'h0 || bus_a.read_finish !== 1'b0 || bus_a.write_finish !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got rdata=%h rf=%b wf=%b want 0/0/0",
                     bus_a.rdata, bus_a.read_finish, bus_a.write_finish);
        end
        step();
    endtask

    task automatic test_read_wait();
        bus_a.ren = 1; bus_a.raddr = 8'h04;
        #1;
        total++;
        if (bus_a.read_finish !== 1'b0) begin
            bad++; $display("FAIL read_c0: got rf=%b want 0", bus_a.read_finish);
        end
        step();
        total++;
        if (bus_a.read_finish !== 1'b1 || bus_a.rdata !== 32'h0) begin
            bad++; $display("FAIL read_c1: got rf=%b rdata=%h want 1 00000000",
                            bus_a.read_finish, bus_a.rdata);
        end
        step();
        bus_a.ren = 0;
        step();
    endtask

    task automatic test_word_write();
        logic [2:0]  seen;
        logic        fin;
        logic [31:0] d;
        bus_a.wen = 1; bus_a.waddr = 8'h08; bus_a.wdata = 32'hDEADBEEF; bus_a.write_width = 2;
        for (int c = 0; c < 3; c++) begin
            #1;
            seen[c] = bus_a.write_finish;
            step();
        end
        bus_a.wen = 0;
        total++;
        if (seen !== 3'b100) begin
            bad++; $display("FAIL write_timing: got wf c2..c0=%b want 100", seen);
        end
        a_read(8'h08, fin, d);
        total++;
        if (fin !== 1'b1 || d !== 32'hDEADBEEF) begin
            bad++; $display("FAIL word_readback: got rf=%b %h want 1 deadbeef", fin, d);
        end
    endtask

    task automatic test_narrow_writes();
        logic        fin;
        logic [31:0] d;
        logic        wf;
        a_write(8'h09, 32'h000000AB, 2'd0);
        a_read(8'h08, fin, d);
        total++;
        if (d !== 32'hDEADABEF) begin
            bad++; $display("FAIL byte_write: got %h want deadabef", d);
        end
        bus_a.wen = 1; bus_a.waddr = 8'h0B; bus_a.wdata = 32'h00001234; bus_a.write_width = 1;
        step(); step();
        #1;
        wf = bus_a.write_finish;
        step();
        bus_a.wen = 0;
        total++;
        if (wf !== 1'b1) begin
            bad++; $display("FAIL misaligned_half_finish: got wf=%b want 1", wf);
        end
        a_read(8'h08, fin, d);
        total++;
        if (d !== 32'hDEADABEF) begin
            bad++; $display("FAIL misaligned_half_nowrite: got %h want deadabef", d);
        end
        a_write(8'h0A, 32'h00005566, 2'd1);
        a_read(8'h08, fin, d);
        total++;
        if (d !== 32'h5566ABEF) begin
            bad++; $display("FAIL aligned_half_write: got %h want 5566abef", d);
        end
        a_write(8'h08, 32'hFFFFFFFF, 2'd3);
        a_read(8'h08, fin, d);
        total++;
        if (d !== 32'h5566ABEF) begin
            bad++; $display("FAIL reserved_width_nowrite: got %h want 5566abef", d);
        end
    endtask

    task automatic test_abort_restart();
        logic [6:0] seen;
        bus_b.ren = 1; bus_b.raddr = 8'h00;
        #1; seen[0] = bus_b.read_finish; step();
        #1; seen[1] = bus_b.read_finish; step();
        bus_b.ren = 0;
        #1; seen[2] = bus_b.read_finish; step();
        bus_b.ren = 1;
        for (int c = 3; c < 7; c++) begin
            #1; seen[c] = bus_b.read_finish; step();
        end
        total++;
        if (seen !== 7'b1000000) begin
            bad++; $display("FAIL abort_restart: got rf c6..c0=%b want 1000000", seen);
        end
        #1;
        total++;
        if (bus_b.read_finish !== 1'b0) begin
            bad++; $display("FAIL back_to_back_c0: got rf=%b want 0", bus_b.read_finish);
        end
        bus_b.ren = 0;
        step();
    endtask

    task automatic test_concurrent();
        bus_c.wen = 1; bus_c.waddr = 8'h08; bus_c.wdata = 32'hDEADABEF; bus_c.write_width = 2;
        step(); step();
        bus_c.wdata = 32'h12345678;
        bus_c.ren = 1; bus_c.raddr = 8'h08;
        #1;
        total++;
        if (bus_c.read_finish !== 1'b0 || bus_c.write_finish !== 1'b0) begin
            bad++; $display("FAIL concurrent_c0: got rf=%b wf=%b want 0 0",
                            bus_c.read_finish, bus_c.write_finish);
        end
        step();
        total++;
        if (bus_c.read_finish !== 1'b1 || bus_c.write_finish !== 1'b1 || bus_c.rdata !== 32'hDEADABEF) begin
            bad++; $display("FAIL concurrent_c1: got rf=%b wf=%b %h want 1 1 deadabef",
                            bus_c.read_finish, bus_c.write_finish, bus_c.rdata);
        end
        step();
        bus_c.wen = 0;
        step();
        total++;
        if (bus_c.read_finish !== 1'b1 || bus_c.rdata !== 32'h12345678) begin
            bad++; $display("FAIL concurrent_next_read: got rf=%b %h want 1 12345678",
                            bus_c.read_finish, bus_c.rdata);
        end
        step();
        bus_c.ren = 0;
        step();
    endtask

    task automatic test_out_of_range_and_reset();
        logic        fin;
        logic [31:0] d;
        logic        wf;
        bus_a.wen = 1; bus_a.waddr = 8'h40; bus_a.wdata = 32'hCAFEF00D; bus_a.write_width = 2;
        step(); step();
        #1; wf = bus_a.write_finish;
        step();
        bus_a.wen = 0;
        total++;
        if (wf !== 1'b1) begin
            bad++; $display("FAIL oor_write_finish: got wf=%b want 1", wf);
        end
        a_read(8'h40, fin, d);
        total++;
        if (fin !== 1'b1 || d !== 32'h0) begin
            bad++; $display("FAIL oor_read: got rf=%b %h want 1 00000000", fin, d);
        end
        a_read(8'h00, fin, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL oor_no_alias: got %h want 00000000", d);
        end
        a_read(8'h08, fin, d);
        total++;
        if (d !== 32'h5566ABEF) begin
            bad++; $display("FAIL oor_word8_kept: got %h want 5566abef", d);
        end
        bus_a.wen = 1; bus_a.waddr = 8'h0C; bus_a.wdata = 32'h55AA55AA; bus_a.write_width = 2;
        step(); step();
        rst_n = 0;
        #1; wf = bus_a.write_finish;
        step();
        rst_n = 1;
        bus_a.wen = 0;
        total++;
        if (wf !== 1'b1) begin
            bad++; $display("FAIL reset_mid_write_strobe: got wf=%b want 1", wf);
        end
        a_read(8'h0C, fin, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL reset_mid_write_nocommit: got %h want 00000000", d);
        end
        a_read(8'h08, fin, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL reset_clears_mem: got %h want 00000000", d);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 0;
        idle_all();
        test_reset();
        test_read_wait();
        test_word_write();
        test_narrow_writes();
        test_abort_restart();
        test_concurrent();
        test_out_of_range_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
